// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : ram_port_arbiter_if
// Brief  : Requester-side and RAM-side signal bundle for ram_port_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8
);
   localparam int c_BE_W = DATA_WIDTH / BYTE_WIDTH;

   logic [NUM_REQ-1:0]            req_valid_i;
   logic [NUM_REQ-1:0]            req_ready_o;
   logic [NUM_REQ-1:0]            req_lock_i;
   logic [NUM_REQ-1:0]            req_we_i;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
   logic [NUM_REQ*c_BE_W-1:0]     req_be_i;
   logic [NUM_REQ-1:0]            rsp_valid_o;
   logic [DATA_WIDTH-1:0]         rsp_rdata_o;
   logic [ADDR_WIDTH-1:0]         ram_addr_o;
   logic [DATA_WIDTH-1:0]         ram_wdata_o;
   logic [c_BE_W-1:0]             ram_we_o;
   logic [DATA_WIDTH-1:0]         ram_rdata_i;

   // Arbiter side
   modport slave (
      input  req_valid_i, req_lock_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
      input  ram_rdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o,
      output ram_addr_o, ram_wdata_o, ram_we_o
   );

   // Requesters plus RAM (environment side)
   modport master (
      output req_valid_i, req_lock_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
      output ram_rdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o,
      input  ram_addr_o, ram_wdata_o, ram_we_o
   );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ram_port_arbiter
// Brief  : Round-robin arbiter with burst lock sharing one single-port RAM.
// Rev    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8
) (
   input  wire logic             clk_i,
   input  wire logic             rst_i,
   ram_port_arbiter_if.slave     io_bus
);
   localparam int c_BE_W  = DATA_WIDTH / BYTE_WIDTH;
   localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [0:0] {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_PTR_W-1:0]   r_rr_ptr;
   logic [c_PTR_W-1:0]   w_rr_ptr_nxt;
   logic [c_PTR_W-1:0]   r_owner;
   logic [c_PTR_W-1:0]   w_owner_nxt;
   logic [NUM_REQ-1:0]   r_rsp_valid;
   logic                 r_rsp_read;

   logic                 w_gnt_vld;
   logic [c_PTR_W-1:0]   w_gnt_idx;
   logic [NUM_REQ-1:0]   w_gnt_oh;
   logic                 w_acc_we;
   logic                 w_acc_lock;

   logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];
   logic [c_BE_W-1:0]     w_be_arr    [NUM_REQ];

   generate
      for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
         assign w_addr_arr[g]  = io_bus.req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
         assign w_wdata_arr[g] = io_bus.req_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
         assign w_be_arr[g]    = io_bus.req_be_i[g*c_BE_W +: c_BE_W];
      end
   endgenerate

   // Grant selection: owner only while locked, otherwise first valid from rr_ptr.
   always_comb begin
      logic [c_PTR_W-1:0] v_cand;
      v_cand    = '0;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      if (!rst_i) begin
         if (r_state == ST_LOCK) begin
            if (io_bus.req_valid_i[r_owner]) begin
               w_gnt_vld = 1'b1;
               w_gnt_idx = r_owner;
            end
         end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
               v_cand = c_PTR_W'((int'(r_rr_ptr) + i) % NUM_REQ);
               if (!w_gnt_vld && io_bus.req_valid_i[v_cand]) begin
                  w_gnt_vld = 1'b1;
                  w_gnt_idx = v_cand;
               end
            end
         end
      end
   end

   assign w_gnt_oh   = w_gnt_vld ? (NUM_REQ'(1) << w_gnt_idx) : '0;
   assign w_acc_we   = w_gnt_vld & io_bus.req_we_i[w_gnt_idx];
   assign w_acc_lock = w_gnt_vld & io_bus.req_lock_i[w_gnt_idx];

   assign io_bus.req_ready_o = w_gnt_oh;
   assign io_bus.ram_addr_o  = w_gnt_vld ? w_addr_arr[w_gnt_idx]  : '0;
   assign io_bus.ram_wdata_o = w_gnt_vld ? w_wdata_arr[w_gnt_idx] : '0;
   assign io_bus.ram_we_o    = w_acc_we  ? w_be_arr[w_gnt_idx]    : '0;

   always_comb begin
      w_state_nxt  = r_state;
      w_rr_ptr_nxt = r_rr_ptr;
      w_owner_nxt  = r_owner;
      case (r_state)
         ST_ARB: begin
            if (w_gnt_vld) begin
               w_rr_ptr_nxt = (w_gnt_idx == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
               if (w_acc_lock) begin
                  w_state_nxt = ST_LOCK;
                  w_owner_nxt = w_gnt_idx;
               end
            end
         end
         ST_LOCK: begin
            // Release only on an accepted owner beat that drops lock.
            if (w_gnt_vld && !w_acc_lock) begin
               w_state_nxt = ST_ARB;
            end
         end
         default: begin
            w_state_nxt = ST_ARB;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_ARB;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_rsp_valid <= '0;
         r_rsp_read  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_owner     <= w_owner_nxt;
         r_rsp_valid <= w_gnt_oh;
         r_rsp_read  <= w_gnt_vld & ~w_acc_we;
      end
   end

   // A response still in flight when reset arrives is dropped.
   assign io_bus.rsp_valid_o = rst_i ? '0 : r_rsp_valid;
   assign io_bus.rsp_rdata_o = (r_rsp_read && !rst_i) ? io_bus.ram_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_port_arbiter
// Brief  : Self-checking bench: vector table, directed corners, random vs model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;
   localparam int N   = 3;
   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int BW  = 8;
   localparam int BEW = DW / BW;
   localparam int PW  = $clog2(N);

   logic clk;
   logic rst;
   logic ram_init;

   ram_port_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();

   ram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic          t_valid [N];
   logic          t_lock  [N];
   logic          t_we    [N];
   logic [AW-1:0] t_addr  [N];
   logic [DW-1:0] t_wdata [N];
   logic [BEW-1:0] t_be   [N];

   generate
      for (genvar g = 0; g < N; g++) begin : g_drv
         assign bus.req_valid_i[g]            = t_valid[g];
         assign bus.req_lock_i[g]             = t_lock[g];
         assign bus.req_we_i[g]               = t_we[g];
         assign bus.req_addr_i[g*AW +: AW]    = t_addr[g];
         assign bus.req_wdata_i[g*DW +: DW]   = t_wdata[g];
         assign bus.req_be_i[g*BEW +: BEW]    = t_be[g];
      end
   endgenerate

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      return {8'hA5, a, ~a, 8'h3C};
   endfunction

   // Byte-lane RAM with one-cycle read latency, read-old-data.
   logic [DW-1:0] ram [256];
   always @(posedge clk) begin
      if (ram_init) begin
         for (int a = 0; a < 256; a++) ram[a] <= init_word(AW'(a));
      end else begin
         bus.ram_rdata_i <= ram[bus.ram_addr_o];
         for (int l = 0; l < BEW; l++)
            if (bus.ram_we_o[l]) ram[bus.ram_addr_o][l*BW +: BW] <= bus.ram_wdata_o[l*BW +: BW];
      end
   end

   int tests = 0;
   int fails = 0;

   // Reference model state
   int            m_ptr;
   bit            m_locked;
   int            m_owner;
   logic [N-1:0]  m_rsp_valid;
   logic [DW-1:0] m_rsp_rdata;
   logic [DW-1:0] m_mem [256];

   logic [N-1:0]   cur_ready;
   logic [N-1:0]   cur_rsp;
   logic [DW-1:0]  cur_rdata;
   logic [BEW-1:0] cur_we;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_grant();
      if (rst) return -1;
      if (m_locked) return t_valid[m_owner] ? m_owner : -1;
      for (int i = 0; i < N; i++)
         if (t_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
      return -1;
   endfunction

   // Inputs are set just after a rising edge; outputs are sampled mid-cycle.
   task automatic tick();
      int g;
      logic [N-1:0]   e_ready;
      logic [BEW-1:0] e_we;
      #4;
      g = model_grant();
      e_ready = (g >= 0) ? (N'(1) << g) : '0;
      e_we    = (g >= 0 && t_we[g]) ? t_be[g] : '0;
      cur_ready = bus.req_ready_o;
      cur_rsp   = bus.rsp_valid_o;
      cur_rdata = bus.rsp_rdata_o;
      cur_we    = bus.ram_we_o;
      check("ready", cur_ready, e_ready);
      check("ram_we", cur_we, e_we);
      if (!rst) begin
         check("rsp_valid", cur_rsp, m_rsp_valid);
         check("rsp_rdata", cur_rdata, m_rsp_rdata);
         check("ram_addr", bus.ram_addr_o, (g >= 0) ? t_addr[g] : '0);
         check("ram_wdata", bus.ram_wdata_o, (g >= 0) ? t_wdata[g] : '0);
      end
      if (rst) begin
         m_ptr = 0; m_locked = 0; m_owner = 0;
         m_rsp_valid = '0; m_rsp_rdata = '0;
      end else begin
         m_rsp_valid = e_ready;
         m_rsp_rdata = (g >= 0 && !t_we[g]) ? m_mem[t_addr[g]] : '0;
         if (g >= 0) begin
            if (t_we[g])
               for (int l = 0; l < BEW; l++)
                  if (t_be[g][l]) m_mem[t_addr[g]][l*BW +: BW] = t_wdata[g][l*BW +: BW];
            if (!m_locked) begin
               m_ptr = (g + 1) % N;
               if (t_lock[g]) begin m_locked = 1; m_owner = g; end
            end else if (!t_lock[g]) begin
               m_locked = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < N; k++) begin
         t_valid[k] = 0; t_lock[k] = 0; t_we[k] = 0;
         t_addr[k] = '0; t_wdata[k] = '0; t_be[k] = '0;
      end
   endtask

   task automatic set_req(input int k, input logic v, input logic lk, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
      t_valid[k] = v; t_lock[k] = lk; t_we[k] = we;
      t_addr[k] = a; t_wdata[k] = d; t_be[k] = be;
   endtask

   // Everyone requests a full write during reset: nothing may be granted or written.
   task automatic apply_reset();
      rst = 1;
      for (int k = 0; k < N; k++) set_req(k, 1, 1, 1, AW'(k), 32'hFFFF_FFFF, 4'hF);
      tick();
      tick();
      rst = 0;
      clear_inputs();
   endtask

   typedef struct {
      logic [N-1:0] valid;
      logic [N-1:0] lock;
      logic [N-1:0] exp_ready;
      logic [N-1:0] exp_rsp;
   } vec_t;
   vec_t tbl [14];

   int cnt [N];

   initial begin
      tbl[0]  = '{3'b111, 3'b000, 3'b001, 3'b000};
      tbl[1]  = '{3'b111, 3'b000, 3'b010, 3'b001};
      tbl[2]  = '{3'b111, 3'b000, 3'b100, 3'b010};
      tbl[3]  = '{3'b110, 3'b000, 3'b010, 3'b100};
      tbl[4]  = '{3'b001, 3'b000, 3'b001, 3'b010};
      tbl[5]  = '{3'b101, 3'b100, 3'b100, 3'b001};
      tbl[6]  = '{3'b011, 3'b000, 3'b000, 3'b100};
      tbl[7]  = '{3'b111, 3'b100, 3'b100, 3'b000};
      tbl[8]  = '{3'b111, 3'b000, 3'b100, 3'b100};
      tbl[9]  = '{3'b111, 3'b000, 3'b001, 3'b100};
      tbl[10] = '{3'b000, 3'b000, 3'b000, 3'b001};
      tbl[11] = '{3'b010, 3'b010, 3'b010, 3'b000};
      tbl[12] = '{3'b111, 3'b000, 3'b010, 3'b010};
      tbl[13] = '{3'b111, 3'b000, 3'b100, 3'b010};

      for (int a = 0; a < 256; a++) m_mem[a] = init_word(AW'(a));
      m_ptr = 0; m_locked = 0; m_owner = 0; m_rsp_valid = '0; m_rsp_rdata = '0;
      clear_inputs();
      rst = 1;
      ram_init = 1;
      @(posedge clk);
      #1;
      ram_init = 0;

      // Two reads back to back: requester 0 first, then 1
      apply_reset();
      set_req(0, 1, 0, 0, 8'h10, '0, '0);
      set_req(1, 1, 0, 0, 8'h20, '0, '0);
      tick();
      check("r037_ready0", cur_ready, 3'b001);
      t_valid[0] = 0;
      tick();
      check("r037_ready1", cur_ready, 3'b010);
      check("r037_rsp0", cur_rsp, 3'b001);
      check("r037_rdata0", cur_rdata, 32'hA510_EF3C);
      clear_inputs();
      tick();
      check("r037_rsp1", cur_rsp, 3'b010);
      check("r037_rdata1", cur_rdata, 32'hA520_DF3C);

      // Partial write then read-back keeps the old upper bytes
      apply_reset();
      set_req(0, 1, 0, 1, 8'h05, 32'hDEAD_BEEF, 4'b0011);
      tick();
      check("r039_we", cur_we, 4'b0011);
      set_req(0, 1, 0, 0, 8'h05, '0, '0);
      tick();
      check("r039_wrsp", cur_rsp, 3'b001);
      clear_inputs();
      tick();
      check("r039_rdata", cur_rdata, 32'hA505_BEEF);

      // Requester 1 holds a 4-beat locked burst while requester 0 waits
      apply_reset();
      set_req(0, 1, 0, 0, 8'h01, '0, '0);
      tick();
      check("r038_pre", cur_ready, 3'b001);
      set_req(1, 1, 1, 0, 8'h02, '0, '0);
      for (int b = 0; b < 4; b++) begin
         t_lock[1] = (b < 3);
         tick();
         check("r038_burst", cur_ready, 3'b010);
      end
      t_lock[1] = 0;
      tick();
      check("r038_after", cur_ready, 3'b001);

      // Continuous full load: strict rotation, three grants each
      apply_reset();
      for (int k = 0; k < N; k++) begin
         set_req(k, 1, 0, 0, AW'(k + 8'h40), '0, '0);
         cnt[k] = 0;
      end
      for (int c = 0; c < 3 * N; c++) begin
         tick();
         check("r040_order", cur_ready, N'(1) << (c % N));
         for (int k = 0; k < N; k++) if (cur_ready[PW'(k)]) cnt[k]++;
      end
      for (int k = 0; k < N; k++) check("r040_count", 64'(cnt[k]), 64'd3);

      // Vector table from a clean reset
      apply_reset();
      for (int i = 0; i < 14; i++) begin
         for (int k = 0; k < N; k++)
            set_req(k, tbl[i].valid[PW'(k)], tbl[i].lock[PW'(k)], 0, AW'($urandom_range(0, 255)), '0, '0);
         tick();
         check("tbl_ready", cur_ready, tbl[i].exp_ready);
         check("tbl_rsp", cur_rsp, tbl[i].exp_rsp);
      end

      // Reset in the middle of a locked burst
      apply_reset();
      set_req(2, 1, 1, 0, 8'h30, '0, '0);
      tick();
      check("r041_lock", cur_ready, 3'b100);
      set_req(0, 1, 0, 0, 8'h31, '0, '0);
      set_req(1, 1, 0, 0, 8'h32, '0, '0);
      tick();
      check("r041_burst", cur_ready, 3'b100);
      rst = 1;
      for (int k = 0; k < N; k++) set_req(k, 1, 1, 1, 8'h33, 32'h1234_5678, 4'hF);
      tick();
      check("r041_rst_ready", cur_ready, 3'b000);
      check("r041_rst_we", cur_we, 4'b0000);
      rst = 0;
      for (int k = 0; k < N; k++) set_req(k, 1, 0, 0, 8'h34, '0, '0);
      tick();
      check("r041_arb", cur_ready, 3'b001);
      check("r041_norsp", cur_rsp, 3'b000);

      // Random traffic against the model
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 49) == 0);
         for (int k = 0; k < N; k++)
            set_req(k, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                    BEW'($urandom_range(0, 15)));
         tick();
      end
      rst = 0;
      clear_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
